// File: rtl/voter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : voter_pkg
// Purpose : Shared types and sizes for the majority-voter self-test block.
//           Holds the sequencer state enum, the pattern width, the error
//           counter width and its saturation value.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package voter_pkg;

  localparam int PAT_W = 3;
  localparam int ERR_W = 4;
  localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/majority_ref.sv
`default_nettype none
// ============================================================================
// Module  : majority_ref
// Purpose : Combinational golden model of a three-input majority voter.
//           Reusable by the self-test checker and by benches.
// Ports   : a, b, c  - voter inputs
//           expected - majority of a, b, c (ab | ac | bc)
// Revision: 1.0 - initial release
// ============================================================================
module majority_ref (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic expected
);

  assign expected = (a & b) | (a & c) | (b & c);

endmodule
`default_nettype wire

// File: rtl/voter_bist.sv
`default_nettype none
// ============================================================================
// Module  : voter_bist
// Purpose : Self-test driver and checker for a three-input majority voter.
//           On start it sweeps {A,B,C} through 000..111 for PASSES sweeps,
//           holding each pattern STEP_CYCLES cycles, samples F on the last
//           cycle of each hold and compares it with the golden majority.
// Params  : STEP_CYCLES (>=1) - cycles each pattern is held
//           PASSES      (>=1) - full 8-pattern sweeps per run
// Ports   : clk, rst_n (async, active low), start, F (voter output)
//           A, B, C, pattern  - driven voter inputs, pattern = {A,B,C}
//           busy              - high while patterns are being driven
//           done              - one-cycle pulse at end of run
//           pass              - sticky, set when a run ends error-free
//           err_cnt           - saturating mismatch count of current run
//           fail_valid, fail_pattern - first failing pattern of the run
// Config  : VOTER_BIST_FAIL_LOG_EN enables first-failure capture; without it
//           fail_valid/fail_pattern are tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module voter_bist
  import voter_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int PASSES      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             F,
  output logic             A,
  output logic             B,
  output logic             C,
  output logic [PAT_W-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [PAT_W-1:0] fail_pattern
);

  // Counters need at least one bit even when their range collapses to 0..0.
  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PASS_W-1:0] c_pass_last = PASS_W'(PASSES - 1);
  localparam logic [PAT_W-1:0]  c_pat_last  = {PAT_W{1'b1}};

  state_t             r_state;
  state_t             w_state_next;
  logic [STEP_W-1:0]  r_step;
  logic [PASS_W-1:0]  r_pass_cnt;
  logic [PAT_W-1:0]   r_pattern;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [ERR_W-1:0]   w_err_next;
  logic               r_pass;
  logic               w_launch;
  logic               w_sample;
  logic               w_last_pat;
  logic               w_expected;
  logic               w_mismatch;

  majority_ref u_ref (
    .a        (r_pattern[2]),
    .b        (r_pattern[1]),
    .c        (r_pattern[0]),
    .expected (w_expected)
  );

  // F is only trusted on the final cycle of a hold; earlier cycles are
  // settling time for the voter.
  assign w_sample   = (r_state == DRIVE) && (r_step == c_step_last);
  assign w_mismatch = (F != w_expected);
  assign w_last_pat = (r_pattern == c_pat_last) && (r_pass_cnt == c_pass_last);
  assign w_err_next = (w_mismatch && (r_err_cnt != ERR_MAX)) ?
                      r_err_cnt + ERR_W'(1) : r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = DRIVE;
          w_launch     = 1'b1;
        end
      end
      DRIVE: begin
        busy = 1'b1;
        if (w_sample && w_last_pat) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_pass_cnt <= '0;
      r_pattern  <= '0;
      r_err_cnt  <= '0;
      r_pass     <= 1'b0;
    end else if (w_launch) begin
      r_step     <= '0;
      r_pass_cnt <= '0;
      r_pattern  <= '0;
      r_err_cnt  <= '0;
      r_pass     <= 1'b0;
    end else if (r_state == DRIVE) begin
      if (w_sample) begin
        r_step    <= '0;
        r_err_cnt <= w_err_next;
        if (r_pattern != c_pat_last) begin
          r_pattern <= r_pattern + PAT_W'(1);
        end else if (r_pass_cnt != c_pass_last) begin
          r_pattern  <= '0;
          r_pass_cnt <= r_pass_cnt + PASS_W'(1);
        end else begin
          // Final sample: the verdict must include this sample's result,
          // so it is taken from the next-count value, not the register.
          r_pattern <= '0;
          r_pass    <= (w_err_next == '0);
        end
      end else begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  assign pattern = r_pattern;
  assign A       = r_pattern[2];
  assign B       = r_pattern[1];
  assign C       = r_pattern[0];
  assign err_cnt = r_err_cnt;
  assign pass    = r_pass;

`ifdef VOTER_BIST_FAIL_LOG_EN
  logic             r_fail_valid;
  logic [PAT_W-1:0] r_fail_pattern;

  // Only the first failure of a run is kept; fail_valid blocks overwrite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_valid   <= 1'b0;
      r_fail_pattern <= '0;
    end else if (w_launch) begin
      r_fail_valid   <= 1'b0;
      r_fail_pattern <= '0;
    end else if (w_sample && w_mismatch && !r_fail_valid) begin
      r_fail_valid   <= 1'b1;
      r_fail_pattern <= r_pattern;
    end
  end

  assign fail_valid   = r_fail_valid;
  assign fail_pattern = r_fail_pattern;
`else
  assign fail_valid   = 1'b0;
  assign fail_pattern = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_voter_bist.sv
`default_nettype none
// ============================================================================
// Module  : tb_voter_bist
// Purpose : Self-checking bench for voter_bist. Three instances cover the
//           default configuration, STEP_CYCLES=1 and PASSES=4. Each drives a
//           bench voter whose output is correct, stuck-at-0 or stuck-at-1.
//           A timeline model predicts every output from the start edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_voter_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [1:0] fm [3];        // 0: correct voter, 1: F stuck 0, 2: F stuck 1

  logic [2:0] a_v, b_v, c_v, busy_v, done_v, pass_v, fv_v, f_v;
  logic [2:0] pat_v [3];
  logic [2:0] fp_v  [3];
  logic [3:0] err_v [3];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  function automatic int step_of(input int d);
    return (d == 1) ? 1 : 4;
  endfunction

  function automatic int passes_of(input int d);
    return (d == 2) ? 4 : 2;
  endfunction

  function automatic logic maj_of(input logic [2:0] p);
    return (int'(p[2]) + int'(p[1]) + int'(p[0])) >= 2;
  endfunction

  function automatic logic voter_out(input logic [1:0] mode, input logic [2:0] p);
    case (mode)
      2'd0:    return maj_of(p);
      2'd1:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  assign f_v[0] = voter_out(fm[0], {a_v[0], b_v[0], c_v[0]});
  assign f_v[1] = voter_out(fm[1], {a_v[1], b_v[1], c_v[1]});
  assign f_v[2] = voter_out(fm[2], {a_v[2], b_v[2], c_v[2]});

  voter_bist #(.STEP_CYCLES(4), .PASSES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .F(f_v[0]),
    .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .pattern(pat_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err_v[0]),
    .fail_valid(fv_v[0]), .fail_pattern(fp_v[0])
  );

  voter_bist #(.STEP_CYCLES(1), .PASSES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .F(f_v[1]),
    .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .pattern(pat_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err_v[1]),
    .fail_valid(fv_v[1]), .fail_pattern(fp_v[1])
  );

  voter_bist #(.STEP_CYCLES(4), .PASSES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .F(f_v[2]),
    .A(a_v[2]), .B(b_v[2]), .C(c_v[2]), .pattern(pat_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err_v[2]),
    .fail_valid(fv_v[2]), .fail_pattern(fp_v[2])
  );

  // ---------------- timeline model ----------------
  // A run is fully described by the edge at which start was accepted and
  // the voter behaviour during it; every output is then a function of the
  // number of edges elapsed since that start edge.
  int         cyc = 0;
  int         s_edge   [3];
  bit         has_run  [3];
  logic [1:0] mode_run [3];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        has_run[d] = 1'b0;
      end else if (start_v[d] &&
                   (!has_run[d] ||
                    cyc >= s_edge[d] + 8 * passes_of(d) * step_of(d) + 2)) begin
        s_edge[d]   = cyc;
        has_run[d]  = 1'b1;
        mode_run[d] = fm[d];
      end
    end
  end

  task automatic expect_of(input int d, output logic [2:0] pat, output logic busy,
                           output logic done, output logic pass, output logic [3:0] err,
                           output logic fv, output logic [2:0] fp);
    int i, st, tot, n, cnt;
    logic [2:0] p;
    pat = 3'd0; busy = 1'b0; done = 1'b0; pass = 1'b0; err = 4'd0;
    fv = 1'b0; fp = 3'd0;
    if (rst_n && has_run[d]) begin
      i   = cyc - s_edge[d];
      st  = step_of(d);
      tot = 8 * passes_of(d);
      cnt = 0;
      if (i < tot * st) begin
        busy = 1'b1;
        pat  = 3'((i / st) % 8);
      end
      done = (i == tot * st);
      n = i / st;
      if (n > tot) n = tot;
      for (int j = 0; j < n; j++) begin
        p = 3'(j % 8);
        if (voter_out(mode_run[d], p) != maj_of(p)) begin
`ifdef VOTER_BIST_FAIL_LOG_EN
          if (cnt == 0) begin
            fv = 1'b1;
            fp = p;
          end
`endif
          cnt++;
        end
      end
      err  = 4'((cnt > 15) ? 15 : cnt);
      pass = (i >= tot * st) && (cnt == 0);
    end
  endtask

  task automatic check(input string name, input int d, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", name, d, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e_pat, e_fp;
    logic       e_busy, e_done, e_pass, e_fv;
    logic [3:0] e_err;
    if (cmp_en) begin
      for (int d = 0; d < 3; d++) begin
        expect_of(d, e_pat, e_busy, e_done, e_pass, e_err, e_fv, e_fp);
        check("pattern",      d, int'(pat_v[d]), int'(e_pat));
        check("abc",          d, int'({a_v[d], b_v[d], c_v[d]}), int'(e_pat));
        check("busy",         d, int'(busy_v[d]), int'(e_busy));
        check("done",         d, int'(done_v[d]), int'(e_done));
        check("pass",         d, int'(pass_v[d]), int'(e_pass));
        check("err_cnt",      d, int'(err_v[d]), int'(e_err));
        check("fail_valid",   d, int'(fv_v[d]), int'(e_fv));
        check("fail_pattern", d, int'(fp_v[d]), int'(e_fp));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int d);
    @(posedge clk); #1 start_v[d] = 1'b1;
    @(posedge clk); #1 start_v[d] = 1'b0;
  endtask

  // Returns edges from the start edge to the done cycle and the number of
  // busy cycles seen; optionally re-pulses start k edges into the run.
  task automatic wait_done(input int d, input int bound, input int repulse,
                           output int edges, output int busy_cnt);
    bit got = 1'b0;
    edges = -1;
    busy_cnt = 0;
    for (int k = 0; k < bound; k++) begin
      if (done_v[d]) begin
        got = 1'b1;
        edges = k;
        break;
      end
      if (busy_v[d]) busy_cnt++;
      start_v[d] = (k == repulse);
      @(posedge clk); #1;
    end
    start_v[d] = 1'b0;
    if (!got) check("done_timeout", d, 0, 1);
  endtask

  task automatic run(input int d, input logic [1:0] mode, input int bound,
                     input int repulse, output int edges, output int busy_cnt);
    fm[d] = mode;
    pulse_start(d);
    wait_done(d, bound, repulse, edges, busy_cnt);
  endtask

  initial begin
    int e, b;
    bit hit;
    rst_n = 1'b0;
    start_v = 3'b000;
    for (int d = 0; d < 3; d++) fm[d] = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",    0, int'(busy_v[0]), 0);
    check("reset_err",     0, int'(err_v[0]), 0);
    check("reset_pattern", 0, int'(pat_v[0]), 0);
    cmp_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // Correct voter, defaults: done in the 65th cycle counting the start cycle.
    run(0, 2'd0, 200, -1, e, b);
    check("t1_done_edges", 0, e, 64);
    check("t1_busy_cycles", 0, b, 64);
    check("t1_pass", 0, int'(pass_v[0]), 1);
    check("t1_err", 0, int'(err_v[0]), 0);

    // F stuck at 0: patterns 011,101,110,111 fail in both passes.
    run(0, 2'd1, 200, -1, e, b);
    check("t2_err", 0, int'(err_v[0]), 8);
    check("t2_pass", 0, int'(pass_v[0]), 0);
`ifdef VOTER_BIST_FAIL_LOG_EN
    check("t2_fail_valid", 0, int'(fv_v[0]), 1);
    check("t2_fail_pattern", 0, int'(fp_v[0]), 3);
`endif

    // Back-to-back: a clean run after the failing one.
    run(0, 2'd0, 200, -1, e, b);
    check("t6_pass", 0, int'(pass_v[0]), 1);
    check("t6_err", 0, int'(err_v[0]), 0);

    // F stuck at 1 with four passes: 16 mismatches saturate at 15.
    run(2, 2'd2, 400, -1, e, b);
    check("t3_done_edges", 2, e, 128);
    check("t3_err", 2, int'(err_v[2]), 15);
    check("t3_pass", 2, int'(pass_v[2]), 0);

    // STEP_CYCLES=1 with a stray start during busy.
    run(1, 2'd0, 60, 5, e, b);
    check("t4_done_edges", 1, e, 16);
    check("t4_busy_cycles", 1, b, 16);
    check("t4_pass", 1, int'(pass_v[1]), 1);

    // Asynchronous reset at pattern 101 mid-run.
    fm[0] = 2'd0;
    pulse_start(0);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (pat_v[0] == 3'd5) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("t5_reached_101", 0, int'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy",    0, int'(busy_v[0]), 0);
    check("t5_rst_pattern", 0, int'(pat_v[0]), 0);
    check("t5_rst_abc",     0, int'({a_v[0], b_v[0], c_v[0]}), 0);
    check("t5_rst_pass",    2, int'(pass_v[2]), 0);
    check("t5_rst_err",     2, int'(err_v[2]), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run(0, 2'd0, 200, -1, e, b);
    check("t5_done_edges", 0, e, 64);
    check("t5_pass", 0, int'(pass_v[0]), 1);
    check("t5_err", 0, int'(err_v[0]), 0);

    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/voter_bist.md
# voter_bist

Self-test driver and checker for the three-input majority voter. Launched by `start`, it sweeps the voter inputs A, B and C through all eight patterns, 000 to 111, for a configurable number of passes. It compares the voter output F against an internally computed majority value and reports an error count, a sticky pass flag and a done pulse. It sits beside the voter in the board top-level and replaces manual switch stimulus.

## Interface
Parameters:
- STEP_CYCLES, default 4: clock cycles each pattern is held; legal range ≥1.
- PASSES, default 2: number of full 8-pattern sweeps per run; legal range ≥1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: launches a run; sampled only in IDLE.
- F, input, 1: voter output under test.
- A, output, 1: voter input, bit 2 of the pattern.
- B, output, 1: voter input, bit 1 of the pattern.
- C, output, 1: voter input, bit 0 of the pattern.
- pattern, output, 3: current {A,B,C}.
- busy, output, 1: high from the first DRIVE cycle through the last sample.
- done, output, 1: one-cycle pulse at end of run.
- pass, output, 1: sticky; set when a run ends with err_cnt==0.
- err_cnt, output, 4: mismatch count for the current or last run; saturates at 15.
- fail_valid, output, 1: see Configuration.
- fail_pattern, output, 3: see Configuration.

## Operation
- FSM states:
  - IDLE: outputs hold their values. `start`=1 moves to DRIVE with pattern=000, pass counter=0 and step counter=0; err_cnt, pass and fail_valid are cleared.
  - DRIVE: drives the pattern. The step counter runs 0..STEP_CYCLES-1. On the cycle with step counter = STEP_CYCLES-1:
    - F is compared with maj(A,B,C) = AB|AC|BC.
    - On mismatch, err_cnt increments; at 15 it holds.
    - The state then advances.
- Advance rules:
  - If pattern<7: pattern+1, stay in DRIVE.
  - If pattern==7 and pass counter<PASSES-1: pattern wraps to 000, pass counter+1, stay in DRIVE.
  - Otherwise go to DONE.
- DONE: lasts one cycle. done=1, busy=0, A/B/C=0, pattern=000. pass is set to (err_cnt==0), using err_cnt including the final sample. Next state is IDLE.
- `start` outside IDLE is ignored. `start` held high in IDLE relaunches on the cycle after DONE.
- Reset, asynchronous at any time including mid-run: state=IDLE and every output = 0. pass=0, err_cnt=0, busy=0, done=0, A=B=C=0, fail_valid=0, fail_pattern=000.

## Timing
- If `start` is sampled high at edge N, busy and pattern=000 appear after edge N.
- Each pattern is driven for exactly STEP_CYCLES cycles. F is sampled at the last edge of that hold, so the voter needs STEP_CYCLES-1 cycles of settling plus combinational delay.
- busy is high for 8·PASSES·STEP_CYCLES cycles. done is high in the single following cycle.
- With defaults, done appears 64 cycles plus 1 after the start edge.
- err_cnt updates the cycle after a failing sample. Its final value is stable when done=1.
- STEP_CYCLES=1: the pattern changes every cycle and F is sampled every edge.

## Configuration
- Macro: VOTER_BIST_FAIL_LOG_EN.
- Defined: the first mismatch of a run latches its pattern into fail_pattern and sets fail_valid. Later mismatches do not overwrite it. Both are cleared on start and on reset.
- Undefined: the capture logic is omitted. fail_valid is tied 0 and fail_pattern is tied 000; the ports remain so the top-level is unchanged.

## Structure
- Shared package voter_pkg holds:
  - the state enum (IDLE, DRIVE, DONE);
  - PAT_W=3;
  - ERR_W=4;
  - ERR_MAX=15.
- Sub-module majority_ref: combinational golden model, expected = AB|AC|BC. It is instantiated once in the checker and is reusable by benches.
- The pattern counter, step counter and pass counter live in the top-level FSM.

## Test plan
- Reset then start with defaults and a correct voter attached: after 65 cycles done=1, pass=1, err_cnt=0; pattern sequence 0..7,0..7, each held 4 cycles.
- F stuck-at-0: err_cnt=8 (4 patterns × 2 passes), pass=0. With the macro defined, fail_pattern=011 and fail_valid=1.
- F stuck-at-1 with PASSES=4: 16 mismatches, so err_cnt saturates at 15 and pass=0.
- STEP_CYCLES=1 with a correct voter: busy high 16 cycles, done on cycle 17, pass=1. A second start pulse during busy is ignored, proven by an unchanged cycle count.
- rst_n asserted at pattern 101 mid-run: all outputs 0 immediately, asynchronously. A new start runs a full clean sweep with err_cnt starting from 0.
- Back-to-back runs: the first run fails, then a correct voter is attached. start clears pass, err_cnt and fail_valid, and the second run ends with pass=1.
